// File: rtl/mac_pipe_sat.sv
// Pipelined signed multiply-accumulate with a configurable multiplier depth,
// explicit accumulator clear, sticky overflow and saturating or wrapping sums.
module mac_pipe_sat #(
    parameter int IN_W        = 8,
    parameter int ACC_W       = 16,
    parameter int MULT_STAGES = 2,
    parameter bit SATURATE    = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    input  logic                    clear_acc,
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    output logic signed [ACC_W-1:0] f,
    output logic                    valid_out,
    output logic                    overflow
);

    localparam int PROD_W = 2 * IN_W;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    function automatic logic sum_ovf(input logic signed [ACC_W:0] s);
        return s[ACC_W] != s[ACC_W-1];
    endfunction

    // Clamp by the sign of the wide sum in saturating mode; otherwise truncate.
    function automatic logic signed [ACC_W-1:0] clamp_sum(input logic signed [ACC_W:0] s);
        if (SATURATE && sum_ovf(s))
            return s[ACC_W] ? ACC_MIN : ACC_MAX;
        return s[ACC_W-1:0];
    endfunction

    logic signed [IN_W-1:0]   a_p0, b_p0;
    logic                     vld_p0, clr_p0;
    logic signed [PROD_W-1:0] prod_p [1:MULT_STAGES];
    logic                     vld_p  [1:MULT_STAGES];
    logic                     clr_p  [1:MULT_STAGES];

    logic signed [ACC_W:0]    base_acc, sum_acc;
    logic                     ovf_now;

    // Stage 0 capture and multiplier stages 1..MULT_STAGES
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_p0   <= '0;
            b_p0   <= '0;
            vld_p0 <= 1'b0;
            clr_p0 <= 1'b0;
            for (int i = 1; i <= MULT_STAGES; i++) begin
                prod_p[i] <= '0;
                vld_p[i]  <= 1'b0;
                clr_p[i]  <= 1'b0;
            end
        end else begin
            vld_p0 <= valid_in;
            clr_p0 <= valid_in & clear_acc;
            if (valid_in) begin
                a_p0 <= a;
                b_p0 <= b;
            end
            prod_p[1] <= PROD_W'(a_p0) * PROD_W'(b_p0);
            vld_p[1]  <= vld_p0;
            clr_p[1]  <= clr_p0;
            for (int i = 2; i <= MULT_STAGES; i++) begin
                prod_p[i] <= prod_p[i-1];
                vld_p[i]  <= vld_p[i-1];
                clr_p[i]  <= clr_p[i-1];
            end
        end
    end

    // Accumulate stage: one guard bit exposes overflow of the ACC_W-bit sum
    always_comb begin
        base_acc = clr_p[MULT_STAGES] ? '0 : (ACC_W+1)'(f);
        sum_acc  = base_acc + (ACC_W+1)'(prod_p[MULT_STAGES]);
        ovf_now  = sum_ovf(sum_acc);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f         <= '0;
            overflow  <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= vld_p[MULT_STAGES];
            if (vld_p[MULT_STAGES]) begin
                f        <= clamp_sum(sum_acc);
                overflow <= (clr_p[MULT_STAGES] ? 1'b0 : overflow) | ovf_now;
            end
        end
    end

endmodule

// File: tb/tb_mac_pipe_sat.sv
// Directed bench for mac_pipe_sat: a saturating and a wrapping instance share
// one stimulus stream; results appear three edges after each sample.
module tb_mac_pipe_sat;

    logic                clk;
    logic                reset;
    logic                valid_in;
    logic                clear_acc;
    logic signed [7:0]   a, b;
    logic signed [15:0]  f_s, f_w;
    logic                vo_s, vo_w, ov_s, ov_w;

    int checks = 0;
    int errors = 0;

    mac_pipe_sat #(.IN_W(8), .ACC_W(16), .MULT_STAGES(2), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .valid_in(valid_in), .clear_acc(clear_acc),
        .a(a), .b(b), .f(f_s), .valid_out(vo_s), .overflow(ov_s)
    );

    mac_pipe_sat #(.IN_W(8), .ACC_W(16), .MULT_STAGES(2), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .valid_in(valid_in), .clear_acc(clear_acc),
        .a(a), .b(b), .f(f_w), .valid_out(vo_w), .overflow(ov_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input int vo, input int fv, input int ov);
        chk({tag, "_vo"}, 32'(vo_s), vo);
        chk({tag, "_f"},  32'(f_s),  fv);
        chk({tag, "_ov"}, 32'(ov_s), ov);
    endtask

    task automatic drive(input logic v, input logic c, input int av, input int bv);
        valid_in  = v;
        clear_acc = c;
        a         = 8'(av);
        b         = 8'(bv);
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        reset = 1'b0;
        valid_in = 1'b0; clear_acc = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk3("reset", 0, 0, 0);
        chk("reset_wrap_f", 32'(f_w), 0);
        reset = 1'b1;

        // Basic accumulate
        drive(1'b1, 1'b0, 2, 2);
        chk("basic_idle_vo", 32'(vo_s), 0);
        drive(1'b1, 1'b0, 3, 3);
        bubble();
        chk("basic_pre_vo", 32'(vo_s), 0);
        bubble();
        chk3("basic_1", 1, 4, 0);
        bubble();
        chk3("basic_2", 1, 13, 0);
        bubble();
        chk3("basic_idle", 0, 13, 0);

        // Bubbles between valid samples, clear_acc ignored while valid_in=0
        drive(1'b1, 1'b1, 2, 2);
        drive(1'b0, 1'b1, 5, 5);
        drive(1'b0, 1'b1, 5, 5);
        drive(1'b1, 1'b0, 6, 6);
        chk3("bub_1", 1, 4, 0);
        bubble();
        chk3("bub_hold1", 0, 4, 0);
        bubble();
        chk3("bub_hold2", 0, 4, 0);
        bubble();
        chk3("bub_2", 1, 40, 0);
        bubble();
        chk("bub_end_vo", 32'(vo_s), 0);

        // Positive saturation; the wrapping instance sees the same stream
        drive(1'b1, 1'b1, 127, 127);
        drive(1'b1, 1'b0, 127, 127);
        drive(1'b1, 1'b0, 127, 127);
        drive(1'b1, 1'b0, 127, 127);
        chk3("psat_1", 1, 16129, 0);
        chk("wrap_1_f", 32'(f_w), 16129);
        drive(1'b1, 1'b0, -1, 1);
        chk3("psat_2", 1, 32258, 0);
        chk("wrap_2_f", 32'(f_w), 32258);
        bubble();
        chk3("psat_3", 1, 32767, 1);
        chk("wrap_3_f", 32'(f_w), -17149);
        chk("wrap_3_ov", 32'(ov_w), 1);
        chk("wrap_3_vo", 32'(vo_w), 1);
        bubble();
        chk3("psat_4", 1, 32767, 1);
        bubble();
        chk3("psat_5", 1, 32766, 1);
        bubble();
        chk3("psat_idle", 0, 32766, 1);

        // Most negative operand squared, with clear
        drive(1'b1, 1'b1, -128, -128);
        bubble(); bubble(); bubble();
        chk3("extreme", 1, 16384, 0);

        // Negative saturation
        drive(1'b1, 1'b1, -128, 127);
        drive(1'b1, 1'b0, -128, 127);
        drive(1'b1, 1'b0, -128, 127);
        bubble();
        chk3("nsat_1", 1, -16256, 0);
        bubble();
        chk3("nsat_2", 1, -32512, 0);
        bubble();
        chk3("nsat_3", 1, -32768, 1);
        bubble();
        chk3("nsat_idle", 0, -32768, 1);

        // Clear after overflow
        drive(1'b1, 1'b1, 2, 3);
        bubble(); bubble(); bubble();
        chk3("clear", 1, 6, 0);

        // Asynchronous reset with a sample in flight
        drive(1'b1, 1'b0, 4, 4);
        bubble();
        #2 reset = 1'b0;
        #1;
        chk3("areset", 0, 0, 0);
        chk("areset_wrap_f", 32'(f_w), 0);
        #1 reset = 1'b1;
        bubble();
        bubble();
        chk3("areset_drop", 0, 0, 0);
        bubble();
        chk("areset_drop2_vo", 32'(vo_s), 0);

        // First sample after reset accumulates onto zero without clear
        drive(1'b1, 1'b0, 1, 5);
        bubble(); bubble(); bubble();
        chk3("post_reset", 1, 5, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_pipe_sat.md
# mac_pipe_sat

Parametrised, pipelined signed multiply-accumulate unit. It is the next generation of the fixed 8x8/16-bit part-3 MAC, adding configurable operand/accumulator widths, a configurable multiplier pipeline depth, an explicit accumulator clear, a sticky overflow flag, and selectable saturating or wrapping accumulation. It sits in the datapath between a valid-qualified operand source and any consumer of the running sum, and accepts one operand pair per clock.

## Interface
- IN_W, 8, signed operand width for a and b.
- ACC_W, 16, signed accumulator/output width; must satisfy ACC_W >= 2*IN_W.
- MULT_STAGES, 2, multiplier pipeline register stages (legal 1..4).
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap.
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- valid_in  in  1  a/b/clear_acc are valid this cycle.
- clear_acc  in  1  with valid_in=1, this sample starts a new accumulation.
- a  in  IN_W  signed operand.
- b  in  IN_W  signed operand.
- f  out  ACC_W  signed accumulated sum (registered).
- valid_out  out  1  one-cycle pulse: f updated by a valid sample at the last edge.
- overflow  out  1  sticky overflow since last clear (registered).

## Operation
- Stage 0: on an edge with valid_in=1, capture a, b and clear_acc into the input register with a valid tag. With valid_in=0, the tag is 0 (bubble) and a, b, and clear_acc are ignored.
- Stages 1..MULT_STAGES: signed product p = a*b, 2*IN_W bits, pipelined. The valid and clear tags travel alongside. The product is sign-extended to ACC_W.
- Accumulate stage, on a valid-tagged entry:
  - base = 0 if the clear tag is set, else the current f.
  - s = base + p, computed at ACC_W+1 bits.
  - ovf_now = 1 if s is outside the ACC_W signed range.
- Result on ovf_now:
  - SATURATE=1: f <= max positive (2^(ACC_W-1)-1) or min negative (-2^(ACC_W-1)), by the sign of s.
  - SATURATE=0: f <= s truncated to ACC_W bits.
  - No overflow: f <= s.
- overflow <= (clear tag ? 0 : overflow) | ovf_now.
  - Sticky until the next clear-tagged sample or reset.
  - Accumulation continues from the saturated or wrapped value.
- Bubbles at the accumulate stage leave f and overflow unchanged and drive valid_out=0.
- clear_acc with valid_in=0 has no effect.
- No back-pressure. A new sample is accepted every cycle and consecutive valid samples accumulate back-to-back with no stall.

## Timing
- Latency: a sample captured at edge k updates f, overflow and valid_out at edge k+MULT_STAGES+1. With defaults, that is k+3.
- valid_out is high for exactly one cycle per valid sample and is never high for a bubble.
- Throughput is one sample per clock.
- Reset (reset=0), taking effect immediately and without waiting for clk:
  - f=0, overflow=0, valid_out=0.
  - All pipeline valid/clear tags are 0 and operand registers are 0.
- Reset mid-operation: in-flight samples are discarded. No valid_out is produced for them after reset deasserts.
- After reset deasserts, the first valid sample accumulates onto f=0 regardless of clear_acc.
- overflow and f change on the same edge. overflow is never combinational.
- Extremes: (-2^(IN_W-1))^2 fits in 2*IN_W signed bits and by itself never raises overflow when ACC_W >= 2*IN_W.

## Test plan
All scenarios use defaults: IN_W=8, ACC_W=16, MULT_STAGES=2, SATURATE=1 unless stated.

- **Basic accumulate:** reset, then valid (2,2) at edge k and valid (3,3) at edge k+1 -> f=4 with valid_out=1 after edge k+3; f=13 with valid_out=1 after edge k+4; overflow=0.
- **Bubbles:** valid (2,2); then valid_in=0 with (5,5) for 2 cycles; then valid (6,6) -> f sequence 4 then 40. valid_out pulses only twice. f holds at 4 during the bubbles.
- **Positive saturation:**
  - Input: valid+clear (127,127), then 3 more valid (127,127), then valid (-1,1).
  - Required f sequence: 16129, 32258, 32767 (overflow rises to 1), 32767, 32766.
  - overflow stays 1 throughout after it rises.
- **Negative saturation:** valid+clear (-128,127) x3 -> f sequence -16256, -32512, -32768 with overflow=1.
- **Wrap mode (SATURATE=0):** valid+clear (127,127) x3 -> f sequence 16129, 32258, -17149 with overflow=1.
- **Clear and async reset:**
  - After an overflow, valid+clear (2,3) -> f=6, overflow=0.
  - Then valid (4,4) at edge k, with reset pulsed low between edges k+1 and k+2 -> f=0, overflow=0, valid_out=0 immediately, and no valid_out pulse at k+3.
